// File: rtl/fim_ram_rd_stream.sv
// Burst reader: issues sequential RAM reads under a credit limit and streams the
// returned words (with last/parity flags) through a small skid FIFO.
module fim_ram_rd_stream #(
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 2   // 1 or 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DEPTH-1:0] req_addr,
  input  logic [DEPTH:0]   req_len,
  output logic             ram_re,
  output logic [DEPTH-1:0] ram_raddr,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic             ram_perr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_perr,
  output logic             done,
  output logic             err_sticky,
  output logic [DEPTH-1:0] err_addr,
  input  logic             err_clr
);

  localparam int L  = RD_LATENCY;
  localparam int FD = RD_LATENCY + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(2 * RD_LATENCY + 3);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             perr;
  } ent_t;

  state_t                state_q, state_d;
  logic                  rdy_q, rdy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DEPTH-1:0]      addr_q, addr_d;
  logic [DEPTH-1:0]      raddr_q, raddr_d;
  logic [DEPTH-1:0]      eaddr_q, eaddr_d;
  logic [DEPTH:0]        rem_q, rem_d;
  logic [CW-1:0]         infl_q, infl_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [L:1]            vld_q, vld_d;
  logic [L:1]            last_q, last_d;
  logic [L:1][DEPTH-1:0] tag_q, tag_d;
  ent_t                  fifo_q [FD];
  ent_t                  fifo_d [FD];
  logic                  accept, issue, push, pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    accept = req_valid & rdy_q;
    // Credit counts only registered occupancy; a pop this cycle frees a slot next cycle.
    issue  = (state_q == ISSUE) && ((infl_q + cnt_q) < CW'(FD));
    push   = vld_q[L];
    pop    = (cnt_q != '0) & out_ready;

    vld_d     = vld_q;
    last_d    = last_q;
    tag_d     = tag_q;
    vld_d[1]  = issue;
    last_d[1] = issue && (rem_q == (DEPTH+1)'(1));
    tag_d[1]  = addr_q;
    for (int i = 2; i <= L; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end

    infl_d = infl_q + CW'(issue) - CW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = '{data: ram_dout, last: last_q[L], perr: ram_perr};
      wptr_d         = inc_ptr(wptr_q);
    end
    if (pop) rptr_d = inc_ptr(rptr_q);

    addr_d  = addr_q;
    rem_d   = rem_q;
    raddr_d = raddr_q;
    if (accept) begin
      addr_d = req_addr;
      rem_d  = req_len;
    end
    if (issue) begin
      raddr_d = addr_q;
      addr_d  = addr_q + 1'b1;
      rem_d   = rem_q - 1'b1;
    end

    // A fresh error outranks a coincident clear and re-captures its address.
    err_d   = err_q;
    eaddr_d = eaddr_q;
    if (err_clr) err_d = 1'b0;
    if (push && ram_perr && (!err_q || err_clr)) begin
      err_d   = 1'b1;
      eaddr_d = tag_q[L];
    end

    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_len == '0) done_d  = 1'b1;
          else               state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue && (rem_q == (DEPTH+1)'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if ((infl_d == '0) && (cnt_d == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      raddr_q <= '0;
      eaddr_q <= '0;
      rem_q   <= '0;
      infl_q  <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      vld_q   <= '0;
      last_q  <= '0;
      tag_q   <= '0;
      for (int i = 0; i < FD; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      eaddr_q <= eaddr_d;
      rem_q   <= rem_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
      fifo_q  <= fifo_d;
    end
  end

  assign req_ready  = rdy_q;
  assign ram_re     = issue;
  assign ram_raddr  = issue ? addr_q : raddr_q;
  assign out_valid  = (cnt_q != '0);
  assign out_data   = fifo_q[rptr_q].data;
  assign out_last   = out_valid & fifo_q[rptr_q].last;
  assign out_perr   = out_valid & fifo_q[rptr_q].perr;
  assign done       = done_q;
  assign err_sticky = err_q;
  assign err_addr   = eaddr_q;

endmodule

// File: tb/tb_fim_ram_rd_stream.sv
// Directed bench for fim_ram_rd_stream with a 2-cycle RAM model; word at address a
// reads back as 32'hC0DE000a.
module tb_fim_ram_rd_stream;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [3:0]  req_addr = '0;
  logic [4:0]  req_len = '0;
  logic        ram_re, ram_perr;
  logic [3:0]  ram_raddr;
  logic [31:0] ram_dout;
  logic        out_valid, out_ready = 1'b1, out_last, out_perr, done;
  logic [31:0] out_data;
  logic        err_sticky, err_clr = 1'b0;
  logic [3:0]  err_addr;

  fim_ram_rd_stream #(.DEPTH(4), .WIDTH(32), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .ram_dout(ram_dout), .ram_perr(ram_perr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_perr(out_perr), .done(done),
    .err_sticky(err_sticky), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data presented two cycles after the read strobe
  logic        p1_vld, p2_vld;
  logic [3:0]  p1_addr, p2_addr;
  logic [15:0] perr_mask = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld <= 1'b0; p2_vld <= 1'b0; p1_addr <= '0; p2_addr <= '0;
    end else begin
      p1_vld <= ram_re; p1_addr <= ram_raddr;
      p2_vld <= p1_vld; p2_addr <= p1_addr;
    end
  end
  assign ram_dout = p2_vld ? {28'hC0DE000, p2_addr} : 32'h0;
  assign ram_perr = p2_vld & perr_mask[p2_addr];

  // monitor
  logic [31:0] beat_data [$];
  logic        beat_last [$];
  logic        beat_perr [$];
  int          beat_cyc  [$];
  logic [3:0]  re_addr   [$];
  int          re_cyc    [$];
  int done_cnt, done_cyc, cred_viol, stab_viol, ov_cnt, buf_m;
  logic prev_stall = 1'b0, pl, pp;
  logic [31:0] pd;

  always @(negedge clk) begin
    if (!rst_n) begin
      buf_m = 0; prev_stall = 1'b0;
    end else begin
      if (ram_re) begin
        re_addr.push_back(ram_raddr); re_cyc.push_back(cyc);
        if (int'(p1_vld) + int'(p2_vld) + buf_m >= 4) cred_viol++;
      end
      if (out_valid) ov_cnt++;
      if (prev_stall && (!out_valid || out_data !== pd || out_last !== pl || out_perr !== pp))
        stab_viol++;
      prev_stall = out_valid && !out_ready;
      pd = out_data; pl = out_last; pp = out_perr;
      if (out_valid && out_ready) begin
        beat_data.push_back(out_data); beat_last.push_back(out_last);
        beat_perr.push_back(out_perr); beat_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      buf_m = buf_m + int'(p2_vld) - int'(out_valid && out_ready);
    end
  end

  int n_chk = 0, n_pass = 0;
  logic mid_st;
  logic [3:0] mid_ad;

  task automatic clr_mon();
    beat_data.delete(); beat_last.delete(); beat_perr.delete(); beat_cyc.delete();
    re_addr.delete(); re_cyc.delete();
    done_cnt = 0; done_cyc = -1; cred_viol = 0; stab_viol = 0; ov_cnt = 0;
  endtask

  // Stimulus only: issue one burst and run until done (plus a few idle cycles).
  task automatic run_burst(input logic [3:0] a, input logic [4:0] l, input bit bp,
                           input bit clr7, output int acc, output bit to);
    clr_mon();
    mid_st = 1'b0; mid_ad = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 20 && !req_ready; k++) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_addr = a; req_len = l; out_ready = 1'b1;
    @(posedge clk); #1;
    acc = cyc; req_valid = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (bp) out_ready = ($urandom_range(0, 99) >= 30);
      err_clr = clr7 && p2_vld && (p2_addr == 4'd7);
      if (err_clr) begin mid_st = err_sticky; mid_ad = err_addr; end
      if (done_cnt != 0) begin to = 1'b0; break; end
    end
    err_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready); else n_pass++;
    n_chk++; if (ram_re !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || err_sticky !== 1'b0)
      $display("FAIL rst_ctrl got re=%b ov=%b done=%b err=%b exp 0000", ram_re, out_valid, done, err_sticky); else n_pass++;
    n_chk++; if (ram_raddr !== 4'd0 || err_addr !== 4'd0 || out_data !== 32'd0 || out_last !== 1'b0 || out_perr !== 1'b0)
      $display("FAIL rst_data got raddr=%0d eaddr=%0d data=%h last=%b perr=%b exp zeros", ram_raddr, err_addr, out_data, out_last, out_perr); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_basic();
    int acc; bit to;
    run_burst(4'd3, 5'd4, 1'b0, 1'b0, acc, to);
    n_chk++; if (to) $display("FAIL basic_timeout got no done exp done"); else n_pass++;
    n_chk++; if (re_addr.size() != 4) $display("FAIL basic_re_count got %0d exp 4", re_addr.size()); else n_pass++;
    for (int i = 0; i < 4 && i < re_addr.size(); i++) begin
      n_chk++; if (re_addr[i] !== 4'(3 + i) || re_cyc[i] != acc + i)
        $display("FAIL basic_raddr[%0d] got %0d@%0d exp %0d@%0d", i, re_addr[i], re_cyc[i], 3 + i, acc + i); else n_pass++;
    end
    n_chk++; if (beat_data.size() != 4) $display("FAIL basic_beats got %0d exp 4", beat_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
      n_chk++; if (beat_data[i] !== (32'hC0DE0000 | 32'(3 + i)) || beat_last[i] !== (i == 3) || beat_cyc[i] != acc + 3 + i)
        $display("FAIL basic_beat[%0d] got %h last=%b @%0d exp %h last=%b @%0d", i, beat_data[i], beat_last[i],
                 beat_cyc[i], 32'hC0DE0000 | 32'(3 + i), (i == 3), acc + 3 + i); else n_pass++;
    end
    n_chk++; if (done_cnt != 1 || done_cyc != acc + 7)
      $display("FAIL basic_done got %0d pulses @%0d exp 1 @%0d", done_cnt, done_cyc, acc + 7); else n_pass++;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL basic_err got %b exp 0", err_sticky); else n_pass++;
  endtask

  task automatic test_wrap();
    int acc; bit to;
    run_burst(4'd14, 5'd4, 1'b0, 1'b0, acc, to);
    n_chk++; if (to || re_addr.size() != 4 || beat_data.size() != 4)
      $display("FAIL wrap_counts got to=%b re=%0d beats=%0d exp 0 4 4", to, re_addr.size(), beat_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < re_addr.size() && i < beat_data.size(); i++) begin
      n_chk++; if (re_addr[i] !== 4'((14 + i) % 16) || beat_data[i] !== (32'hC0DE0000 | 32'((14 + i) % 16)))
        $display("FAIL wrap[%0d] got addr=%0d data=%h exp addr=%0d data=%h", i, re_addr[i], beat_data[i],
                 (14 + i) % 16, 32'hC0DE0000 | 32'((14 + i) % 16)); else n_pass++;
    end
    n_chk++; if (beat_last.size() == 4 && beat_last[3] !== 1'b1)
      $display("FAIL wrap_last got %b exp 1", beat_last[3]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc; bit to; int nlast;
    run_burst(4'd0, 5'd16, 1'b1, 1'b0, acc, to);
    n_chk++; if (to) $display("FAIL bp_timeout got no done exp done"); else n_pass++;
    n_chk++; if (beat_data.size() != 16 || re_addr.size() != 16)
      $display("FAIL bp_counts got beats=%0d re=%0d exp 16 16", beat_data.size(), re_addr.size()); else n_pass++;
    nlast = 0;
    for (int i = 0; i < 16 && i < beat_data.size(); i++) begin
      if (beat_last[i]) nlast++;
      n_chk++; if (beat_data[i] !== (32'hC0DE0000 | 32'(i)))
        $display("FAIL bp_beat[%0d] got %h exp %h", i, beat_data[i], 32'hC0DE0000 | 32'(i)); else n_pass++;
    end
    n_chk++; if (nlast != 1 || (beat_last.size() == 16 && beat_last[15] !== 1'b1))
      $display("FAIL bp_last got %0d lasts exp 1 on beat 15", nlast); else n_pass++;
    n_chk++; if (cred_viol != 0) $display("FAIL bp_credit got %0d issues at full credit exp 0", cred_viol); else n_pass++;
    n_chk++; if (stab_viol != 0) $display("FAIL bp_stable got %0d unstable stalls exp 0", stab_viol); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL bp_done got %0d exp 1", done_cnt); else n_pass++;
  endtask

  task automatic test_perr();
    int acc; bit to;
    perr_mask[5] = 1'b1; perr_mask[7] = 1'b1;
    run_burst(4'd4, 5'd4, 1'b0, 1'b1, acc, to);
    n_chk++; if (to || beat_perr.size() != 4) $display("FAIL perr_counts got to=%b beats=%0d exp 0 4", to, beat_perr.size()); else n_pass++;
    n_chk++; if (mid_st !== 1'b1 || mid_ad !== 4'd5)
      $display("FAIL perr_first got sticky=%b addr=%0d exp 1 5", mid_st, mid_ad); else n_pass++;
    for (int i = 0; i < 4 && i < beat_perr.size(); i++) begin
      n_chk++; if (beat_perr[i] !== (i == 1 || i == 3))
        $display("FAIL perr_beat[%0d] got %b exp %b", i, beat_perr[i], (i == 1 || i == 3)); else n_pass++;
    end
    n_chk++; if (err_sticky !== 1'b1 || err_addr !== 4'd7)
      $display("FAIL perr_clr_coinc got sticky=%b addr=%0d exp 1 7", err_sticky, err_addr); else n_pass++;
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL perr_clear got %b exp 0", err_sticky); else n_pass++;
    run_burst(4'd5, 5'd3, 1'b0, 1'b0, acc, to);
    n_chk++; if (err_sticky !== 1'b1 || err_addr !== 4'd5)
      $display("FAIL perr_keep_first got sticky=%b addr=%0d exp 1 5", err_sticky, err_addr); else n_pass++;
    perr_mask = '0;
  endtask

  task automatic test_len0();
    int acc; bit to;
    run_burst(4'd9, 5'd0, 1'b0, 1'b0, acc, to);
    n_chk++; if (to || done_cnt != 1 || done_cyc != acc)
      $display("FAIL len0_done got to=%b %0d pulses @%0d exp 1 @%0d", to, done_cnt, done_cyc, acc); else n_pass++;
    n_chk++; if (re_addr.size() != 0 || ov_cnt != 0)
      $display("FAIL len0_activity got re=%0d valid_cycles=%0d exp 0 0", re_addr.size(), ov_cnt); else n_pass++;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL len0_ready got %b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc; bit to;
    clr_mon();
    @(posedge clk); #1;
    out_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd0; req_len = 5'd16;
    @(posedge clk); #1;
    acc = cyc; req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL rmid_buffered got out_valid=%b exp 1", out_valid); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if (out_valid !== 1'b0 || ram_re !== 1'b0 || done !== 1'b0)
      $display("FAIL rmid_abort got ov=%b re=%b done=%b exp 000", out_valid, ram_re, done); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (done_cnt != 0 || beat_data.size() != 0)
      $display("FAIL rmid_no_done got done=%0d beats=%0d exp 0 0", done_cnt, beat_data.size()); else n_pass++;
    run_burst(4'd9, 5'd3, 1'b0, 1'b0, acc, to);
    n_chk++; if (to || done_cnt != 1 || beat_data.size() != 3)
      $display("FAIL rmid_next got to=%b done=%0d beats=%0d exp 0 1 3", to, done_cnt, beat_data.size()); else n_pass++;
    for (int i = 0; i < 3 && i < beat_data.size(); i++) begin
      n_chk++; if (beat_data[i] !== (32'hC0DE0000 | 32'(9 + i)) || beat_last[i] !== (i == 2))
        $display("FAIL rmid_beat[%0d] got %h last=%b exp %h last=%b", i, beat_data[i], beat_last[i],
                 32'hC0DE0000 | 32'(9 + i), (i == 2)); else n_pass++;
    end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_perr();
    test_len0();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/fim_ram_rd_stream.md
FIM_RAM_RD_STREAM -- requirements
Module: fim_ram_rd_stream

Interface
REQ-001 Parameter DEPTH, 4, RAM address width in bits.
REQ-002 Parameter WIDTH, 32, RAM data width in bits.
REQ-003 Parameter RD_LATENCY, 2, cycles from ram_re to valid ram_dout/ram_perr; legal values 1 and 2 only.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 Port req_valid/req_ready, input/output, 1/1, burst request handshake.
REQ-007 Port req_addr, input, DEPTH, burst start address.
REQ-008 Port req_len, input, DEPTH+1, burst word count, 0..2^DEPTH.
REQ-009 Port ram_re/ram_raddr, output/output, 1/DEPTH, RAM read strobe and address.
REQ-010 Port ram_dout/ram_perr, input/input, WIDTH/1, RAM read data and parity error, valid RD_LATENCY cycles after ram_re.
REQ-011 Port out_valid/out_ready, output/input, 1/1, read data stream handshake.
REQ-012 Port out_data/out_last/out_perr, output, WIDTH/1/1, word, last-of-burst flag, per-word parity error.
REQ-013 Port done, output, 1, one-cycle pulse at burst completion.
REQ-014 Port err_sticky/err_addr/err_clr, output/output/input, 1/DEPTH/1, sticky parity error, address of first error, clear.

Function
REQ-015 FSM states IDLE, ISSUE, DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-016 Request accepted on req_valid & req_ready; addr and len captured that cycle.
REQ-017 Accepted req_len==0: no ram_re, no out beats, done pulses next cycle, FSM stays IDLE.
REQ-018 Accepted req_len>0: FSM to ISSUE next cycle.
REQ-019 ISSUE: ram_re=1 in a cycle only when in_flight+buf_count < RD_LATENCY+2 (registered values, same-cycle pop not credited).
REQ-020 Each issue: ram_raddr=current address; address then increments modulo 2^DEPTH (wraps 2^DEPTH-1 -> 0); remaining decrements.
REQ-021 Issue of the final word tags it last; FSM moves to DRAIN the next cycle.
REQ-022 In-flight tracking: shift pipeline of RD_LATENCY stages carrying valid, last and address tags; ram_dout/ram_perr sampled into buffer when the stage-RD_LATENCY valid is set.
REQ-023 Output buffer: FIFO of RD_LATENCY+2 entries {data, last, perr}; out_* driven from FIFO head; out_valid = not empty; pop on out_valid & out_ready.
REQ-024 Credit rule guarantees no overflow; returning word never dropped regardless of out_ready.
REQ-025 With out_ready held 1, throughput SHALL be one word per cycle after first-word latency of RD_LATENCY+2 cycles from acceptance.
REQ-026 out_data/out_last/out_perr stable while out_valid & !out_ready.
REQ-027 DRAIN: when in_flight==0 and FIFO empty, done pulses one cycle, FSM to IDLE; earliest done is the cycle after the last beat pop.
REQ-028 Word with ram_perr=1: stored out_perr=1; if err_sticky==0, err_sticky set and err_addr captured from its address tag; later errors leave err_addr unchanged.
REQ-029 err_clr clears err_sticky; err_clr coincident with a new error: error wins, err_addr takes new address.
REQ-030 ram_raddr holds last issued value when ram_re=0.

Reset
REQ-031 rst_n low: FSM IDLE; ram_re, out_valid, out_last, out_perr, done, err_sticky = 0; ram_raddr, err_addr, out_data = 0; FIFO and pipeline emptied.
REQ-032 req_ready SHALL be 0 while rst_n low and 1 from the first clock edge after deassertion.
REQ-033 Reset mid-burst discards all in-flight and buffered words; no done pulse for the aborted burst.

Verification
REQ-034 DEPTH=4, RD_LATENCY=2, req_addr=3, req_len=4, out_ready=1 -> ram_raddr 3,4,5,6 on consecutive cycles, four beats matching RAM contents, out_last on beat 4, done once.
REQ-035 req_addr=14, req_len=4 -> ram_raddr 14,15,0,1 (wrap), data in that order.
REQ-036 req_len=16, out_ready toggled random 30% low -> 16 beats, no loss/duplication, ram_re never issued with in_flight+buf_count=4.
REQ-037 ram_perr=1 on words at addr 5 and 7 -> out_perr on those beats, err_sticky=1, err_addr=5; err_clr pulse coincident with addr-7 error -> err_sticky=1, err_addr=7.
REQ-038 req_len=0 -> no ram_re, no out_valid, done pulses exactly one cycle after acceptance.
REQ-039 rst_n asserted mid-burst with 2 words buffered -> out_valid=0 and ram_re=0 immediately, no done; next burst after reset completes correctly.
